// File: rtl/rans_interleave_ctrl_if.sv
// Symbol-input and merged-output valid/ready streams of the rANS lane scheduler.
// slave is the scheduler side; master is the producer/consumer environment side.
interface rans_interleave_ctrl_if #(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned NUM_LANES    = 4
);
  logic                         s_valid_i;
  logic                         s_ready_o;
  logic [SYMBOL_WIDTH-1:0]      s_symb_i;
  logic                         s_last_i;
  logic                         m_valid_o;
  logic                         m_ready_i;
  logic [SYMBOL_WIDTH-1:0]      m_enc_o;
  logic [$clog2(NUM_LANES)-1:0] m_lane_o;

  modport slave (
    input  s_valid_i, s_symb_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_enc_o, m_lane_o
  );

  modport master (
    output s_valid_i, s_symb_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_enc_o, m_lane_o
  );
endinterface

// File: rtl/rans_interleave_ctrl.sv
// Round-robin symbol dispatcher and tagged byte merger for interleaved rANS encoder lanes.
// Optional statistics counters are built when RANS_IL_STATS_EN is defined.
module rans_interleave_ctrl #(
  parameter int unsigned SYMBOL_WIDTH   = 8,
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned OUT_FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  rans_interleave_ctrl_if.slave             bus,
  input  logic                              freq_wr_i,
  output logic                              freq_busy_o,
  output logic [NUM_LANES-1:0]              lane_en_o,
  output logic [SYMBOL_WIDTH-1:0]           lane_symb_o,
  output logic [NUM_LANES-1:0]              lane_flush_o,
  input  logic [NUM_LANES-1:0]              lane_valid_i,
  input  logic [NUM_LANES*SYMBOL_WIDTH-1:0] lane_enc_i,
`ifdef RANS_IL_STATS_EN
  output logic [31:0]                       stat_sym_o,
  output logic [31:0]                       stat_stall_o,
`endif
  output logic                              err_ovf_o
);
  localparam int unsigned PW = $clog2(NUM_LANES);
  localparam int unsigned DW = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned CW = DW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_FREQ, ST_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     disp_q, disp_d;
  logic              ready, accept;

  logic [NUM_LANES-1:0]    lane_en_q;
  logic [SYMBOL_WIDTH-1:0] lane_symb_q;

  logic [SYMBOL_WIDTH-1:0] mem_q [NUM_LANES][OUT_FIFO_DEPTH];
  logic [DW-1:0]           wr_ptr_q [NUM_LANES];
  logic [DW-1:0]           rd_ptr_q [NUM_LANES];
  logic [CW-1:0]           fcnt_q   [NUM_LANES];
  logic [NUM_LANES-1:0]    full, nempty, push, pop;
  logic                    err_q;

  logic [PW-1:0]           mptr_q, base, idx, win;
  logic                    found, load_ok, hs;
  logic                    m_valid_q;
  logic [SYMBOL_WIDTH-1:0] m_enc_q;
  logic [PW-1:0]           m_lane_q;

  // Readiness is gated by rst_i so the handshake reads as idle while reset is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ready   = !rst_i && (state_q == ST_RUN) && !freq_wr_i
              && (fcnt_q[disp_q] <= CW'(OUT_FIFO_DEPTH - 2));
    accept  = bus.s_valid_i && ready;
    case (state_q)
      ST_RUN: begin
        if (freq_wr_i) begin
          state_d = ST_FREQ;
          cnt_d   = '0;
        end else if (accept) begin
          disp_d = disp_q + 1'b1;
          if (bus.s_last_i) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end
        end
      end
      ST_FREQ: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_RUN;
          disp_d  = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      disp_q      <= '0;
      lane_en_q   <= '0;
      lane_symb_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      lane_en_q <= '0;
      if (accept) begin
        lane_en_q[disp_q] <= 1'b1;
        lane_symb_q       <= bus.s_symb_i;
      end
    end
  end

  // Merge arbitration searches from the post-handshake pointer so a same-cycle reload stays fair.
  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      full[k]   = (fcnt_q[k] == CW'(OUT_FIFO_DEPTH));
      nempty[k] = (fcnt_q[k] != '0);
    end
    push    = lane_valid_i & ~full;
    hs      = m_valid_q && bus.m_ready_i;
    load_ok = !m_valid_q || bus.m_ready_i;
    base    = hs ? m_lane_q + 1'b1 : mptr_q;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      idx = base + PW'(i);
      if (!found && nempty[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    pop = '0;
    if (load_ok && found) pop[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= lane_enc_i[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        fcnt_q[k]   <= '0;
      end
      err_q     <= 1'b0;
      mptr_q    <= '0;
      m_valid_q <= 1'b0;
      m_enc_q   <= '0;
      m_lane_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        fcnt_q[k] <= fcnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
      if (|(lane_valid_i & full)) err_q <= 1'b1;
      if (hs) mptr_q <= m_lane_q + 1'b1;
      if (load_ok) begin
        m_valid_q <= found;
        if (found) begin
          m_enc_q  <= mem_q[win][rd_ptr_q[win]];
          m_lane_q <= win;
        end
      end
    end
  end

`ifdef RANS_IL_STATS_EN
  logic [31:0] stat_sym_q, stat_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_sym_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept && (stat_sym_q != '1)) stat_sym_q <= stat_sym_q + 1'b1;
      if (bus.s_valid_i && !ready && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_sym_o   = stat_sym_q;
  assign stat_stall_o = stat_stall_q;
`endif

  always_comb begin
    lane_flush_o = '0;
    if (state_q == ST_FLUSH) lane_flush_o[cnt_q] = 1'b1;
  end

  assign freq_busy_o   = (state_q == ST_FREQ);
  assign lane_en_o     = lane_en_q;
  assign lane_symb_o   = lane_symb_q;
  assign err_ovf_o     = err_q;
  assign bus.s_ready_o = ready;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_enc_o   = m_enc_q;
  assign bus.m_lane_o  = m_lane_q;
endmodule

// File: tb/tb_rans_interleave_ctrl.sv
// Directed bench for rans_interleave_ctrl: dispatch and merge scoreboards plus inline checks
// of ready, freq/flush sequencing, overflow and asynchronous reset.
module tb_rans_interleave_ctrl;
  localparam int unsigned SW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned D  = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 freq_wr_i;
  logic                 freq_busy_o;
  logic [NL-1:0]        lane_en_o;
  logic [SW-1:0]        lane_symb_o;
  logic [NL-1:0]        lane_flush_o;
  logic [NL-1:0]        lane_valid_i;
  logic [NL*SW-1:0]     lane_enc_i;
  logic                 err_ovf_o;
`ifdef RANS_IL_STATS_EN
  logic [31:0]          stat_sym_o, stat_stall_o;
`endif

  rans_interleave_ctrl_if #(.SYMBOL_WIDTH(SW), .NUM_LANES(NL)) bus ();

  rans_interleave_ctrl #(.SYMBOL_WIDTH(SW), .NUM_LANES(NL), .OUT_FIFO_DEPTH(D)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus.slave),
    .freq_wr_i    (freq_wr_i),
    .freq_busy_o  (freq_busy_o),
    .lane_en_o    (lane_en_o),
    .lane_symb_o  (lane_symb_o),
    .lane_flush_o (lane_flush_o),
    .lane_valid_i (lane_valid_i),
    .lane_enc_i   (lane_enc_i),
`ifdef RANS_IL_STATS_EN
    .stat_sym_o   (stat_sym_o),
    .stat_stall_o (stat_stall_o),
`endif
    .err_ovf_o    (err_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [NL-1:0] en; logic [SW-1:0] symb; } disp_t;
  typedef struct packed { logic [1:0] lane; logic [SW-1:0] enc; } merge_t;
  disp_t  disp_sb[$];
  merge_t merge_sb[$];
  disp_t  de;
  merge_t me;
  logic [1:0] dptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] onehot(input logic [1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && lane_en_o !== '0) begin
      if (disp_sb.size() == 0) check("lane_en_unexpected", 32'(lane_en_o), 32'h0);
      else begin
        de = disp_sb.pop_front();
        check("lane_en", 32'(lane_en_o), 32'(de.en));
        check("lane_symb", 32'(lane_symb_o), 32'(de.symb));
      end
    end
    if (!rst_i && bus.m_valid_o && bus.m_ready_i) begin
      if (merge_sb.size() == 0) check("m_valid_unexpected", 32'(bus.m_valid_o), 32'h0);
      else begin
        me = merge_sb.pop_front();
        check("m_enc", 32'(bus.m_enc_o), 32'(me.enc));
        check("m_lane", 32'(bus.m_lane_o), 32'(me.lane));
      end
    end
  end

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc_sym(input logic [SW-1:0] s, input logic last, input logic exp_rdy);
    bus.s_valid_i = 1'b1;
    bus.s_symb_i  = s;
    bus.s_last_i  = last;
    @(negedge clk_i);
    check("s_ready", 32'(bus.s_ready_o), 32'(exp_rdy));
    if (exp_rdy) begin
      disp_sb.push_back({onehot(dptr), s});
      dptr = dptr + 2'd1;
    end
    nxt();
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  task automatic drain(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && (merge_sb.size() != 0 || disp_sb.size() != 0); i++) nxt();
    check("merge_left", 32'(merge_sb.size()), 32'h0);
    check("disp_left", 32'(disp_sb.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready_o), 32'h0);
    check({tag, "_freq_busy"}, 32'(freq_busy_o), 32'h0);
    check({tag, "_lane_en"}, 32'(lane_en_o), 32'h0);
    check({tag, "_lane_symb"}, 32'(lane_symb_o), 32'h0);
    check({tag, "_lane_flush"}, 32'(lane_flush_o), 32'h0);
    check({tag, "_m_valid"}, 32'(bus.m_valid_o), 32'h0);
    check({tag, "_m_enc"}, 32'(bus.m_enc_o), 32'h0);
    check({tag, "_m_lane"}, 32'(bus.m_lane_o), 32'h0);
    check({tag, "_err_ovf"}, 32'(err_ovf_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    freq_wr_i = 1'b0;
    lane_valid_i = '0;
    lane_enc_i = '0;
    bus.s_valid_i = 1'b0;
    bus.s_symb_i = '0;
    bus.s_last_i = 1'b0;
    bus.m_ready_i = 1'b0;
    dptr = 2'd0;
    nxt();
    nxt();
    @(negedge clk_i);
    check_reset_outputs("rst");
    nxt();
    rst_i = 1'b0;

    // Back-to-back symbols with idle lanes.
    for (int i = 0; i < 8; i++) cyc_sym(8'(8'h10 + i), 1'b0, 1'b1);
    drain(5);

    // Two lanes push in the same cycle.
    bus.m_ready_i = 1'b1;
    lane_valid_i = 4'b0101;
    lane_enc_i = 32'h00C2_00A0;
    merge_sb.push_back({2'd0, 8'hA0});
    merge_sb.push_back({2'd2, 8'hC2});
    nxt();
    lane_valid_i = '0;
    drain(10);

    // Backpressure, lane 1 fills up, overflow.
    bus.m_ready_i = 1'b0;
    lane_valid_i = 4'b0001;
    lane_enc_i = 32'h0000_0055;
    merge_sb.push_back({2'd0, 8'h55});
    cyc_sym(8'h20, 1'b0, 1'b1);
    lane_valid_i = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      lane_enc_i = 32'(8'(8'h30 + k)) << 8;
      merge_sb.push_back({2'd1, 8'(8'h30 + k)});
      @(negedge clk_i);
      check("fill_s_ready", 32'(bus.s_ready_o), 32'(k <= 2));
      if (k >= 1) begin
        check("fill_m_valid", 32'(bus.m_valid_o), 32'h1);
        check("fill_m_enc", 32'(bus.m_enc_o), 32'h55);
      end
      nxt();
    end
    lane_enc_i = 32'h0000_3400;
    @(negedge clk_i);
    check("ovf_before", 32'(err_ovf_o), 32'h0);
    nxt();
    lane_valid_i = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk_i);
      check("ovf_after", 32'(err_ovf_o), 32'h1);
      check("hold_m_enc", 32'(bus.m_enc_o), 32'h55);
      check("hold_m_lane", 32'(bus.m_lane_o), 32'h0);
      check("hold_s_ready", 32'(bus.s_ready_o), 32'h0);
      nxt();
    end
    bus.m_ready_i = 1'b1;
    drain(20);

    // Frequency write collides with a symbol; later write during FREQ is ignored.
    freq_wr_i = 1'b1;
    bus.s_valid_i = 1'b1;
    bus.s_symb_i = 8'h99;
    @(negedge clk_i);
    check("freq_s_ready", 32'(bus.s_ready_o), 32'h0);
    check("freq_busy_pre", 32'(freq_busy_o), 32'h0);
    nxt();
    freq_wr_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) freq_wr_i = 1'b1;
      @(negedge clk_i);
      check("freq_busy", 32'(freq_busy_o), 32'h1);
      check("freq_hold_ready", 32'(bus.s_ready_o), 32'h0);
      nxt();
      freq_wr_i = 1'b0;
    end
    cyc_sym(8'h99, 1'b0, 1'b1);
    @(negedge clk_i);
    check("freq_busy_post", 32'(freq_busy_o), 32'h0);
    nxt();
    drain(5);

    // Flush after the third symbol of a block.
    cyc_sym(8'h40, 1'b0, 1'b1);
    cyc_sym(8'h41, 1'b0, 1'b1);
    cyc_sym(8'h42, 1'b1, 1'b1);
    bus.s_valid_i = 1'b1;
    bus.s_symb_i = 8'h43;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("flush_strobe", 32'(lane_flush_o), 32'(onehot(2'(k))));
      check("flush_s_ready", 32'(bus.s_ready_o), 32'h0);
      nxt();
    end
    dptr = 2'd0;
    cyc_sym(8'h43, 1'b0, 1'b1);
    @(negedge clk_i);
    check("flush_done", 32'(lane_flush_o), 32'h0);
    nxt();
    drain(5);

    // Asynchronous reset in the middle of a flush with bytes queued.
    bus.m_ready_i = 1'b0;
    lane_valid_i = 4'b1001;
    lane_enc_i = 32'h8800_0077;
    nxt();
    lane_valid_i = '0;
    cyc_sym(8'h50, 1'b1, 1'b1);
    @(negedge clk_i);
    check("mid_flush0", 32'(lane_flush_o), 32'h1);
    check("mid_m_valid", 32'(bus.m_valid_o), 32'h1);
    nxt();
    @(negedge clk_i);
    check("mid_flush1", 32'(lane_flush_o), 32'h2);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("async_rst");
    nxt();
    nxt();
    rst_i = 1'b0;
    dptr = 2'd0;
    @(negedge clk_i);
    check("post_rst_m_valid", 32'(bus.m_valid_o), 32'h0);
    check("post_rst_s_ready", 32'(bus.s_ready_o), 32'h1);
    check("post_rst_err", 32'(err_ovf_o), 32'h0);
    check("post_rst_flush", 32'(lane_flush_o), 32'h0);
    nxt();
    bus.m_ready_i = 1'b1;
    cyc_sym(8'h61, 1'b0, 1'b1);
    nxt();
    @(negedge clk_i);
    check("post_rst_empty", 32'(bus.m_valid_o), 32'h0);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
